// File: rtl/prog_loader.sv
// Program loader: streams 30-bit instructions into 10-bit main memory as
// three words (high, mid, low) while holding the CPU in reset.
module prog_loader #(
  parameter int                ADDR_W    = 14,
  parameter int                WORD_W    = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 14'h2000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [3*WORD_W-1:0]   in_instr,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [WORD_W-1:0]     mem_data,
  output logic                  mem_we,
  output logic                  cpu_rst,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [11:0]           count
);

  typedef enum logic [2:0] {IDLE, ACCEPT, W0, W1, W2, DONE, ERR} state_e;

  // Pointer carries one extra bit so advancing past the top never wraps.
  localparam logic [ADDR_W:0] BASE_PTR = {1'b0, BASE_ADDR};
  localparam logic [ADDR_W:0] PTR_MAX  = {1'b0, {ADDR_W{1'b1}}} - (ADDR_W+1)'(2);

  state_e                state_q, state_d;
  logic [ADDR_W:0]       ptr_q, ptr_d;
  logic [11:0]           count_q, count_d;
  logic [3*WORD_W-1:0]   instr_q, instr_d;
  logic                  last_q, last_d;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    count_d  = count_q;
    instr_d  = instr_q;
    last_d   = last_q;
    in_ready = 1'b0;
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_data = '0;
    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d = ACCEPT;
          ptr_d   = BASE_PTR;
          count_d = '0;
        end
      end
      ACCEPT: begin
        in_ready = 1'b1;
        if (in_valid) begin
          instr_d = in_instr;
          last_d  = in_last;
          state_d = (ptr_q > PTR_MAX) ? ERR : W0;
        end
      end
      W0: begin
        mem_we   = 1'b1;
        mem_addr = ptr_q[ADDR_W-1:0];
        mem_data = instr_q[3*WORD_W-1:2*WORD_W];
        state_d  = W1;
      end
      W1: begin
        mem_we   = 1'b1;
        mem_addr = ptr_q[ADDR_W-1:0] + ADDR_W'(1);
        mem_data = instr_q[2*WORD_W-1:WORD_W];
        state_d  = W2;
      end
      W2: begin
        mem_we   = 1'b1;
        mem_addr = ptr_q[ADDR_W-1:0] + ADDR_W'(2);
        mem_data = instr_q[WORD_W-1:0];
        ptr_d    = ptr_q + (ADDR_W+1)'(3);
        count_d  = (count_q == 12'hFFF) ? count_q : count_q + 12'd1;
        state_d  = last_q ? DONE : ACCEPT;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= BASE_PTR;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

  // Instruction holding register is pure data; only read after a capture.
  always_ff @(posedge clk) begin
    instr_q <= instr_d;
    last_q  <= last_d;
  end

  assign cpu_rst = (state_q != DONE);
  assign busy    = (state_q == ACCEPT) || (state_q == W0) ||
                   (state_q == W1) || (state_q == W2);
  assign done    = (state_q == DONE);
  assign error   = (state_q == ERR);
  assign count   = count_q;

endmodule

// File: doc/prog_loader.md
# prog_loader

Program loader that writes 30-bit instructions into the 10-bit-wide main memory as three consecutive words, i.e. the writer side of the CPU's three-word instruction fetch. It holds the CPU in reset while loading, accepts instructions over a valid/ready stream, and releases the CPU once the last instruction is stored. It sits between the host/boot stream and the memory write port, which it muxes in ahead of the CPU while `cpu_rst` is high.

## Interface
- `ADDR_W`, 14, memory address width
- `WORD_W`, 10, memory word width; instruction width is 3*WORD_W = 30
- `BASE_ADDR`, 14'h2000, first load address; equals the CPU reset PC
- `clk  in  1`  system clock, all state on rising edge
- `rst_n  in  1`  asynchronous, active-low reset
- `start  in  1`  one-cycle pulse that begins a load session
- `in_valid  in  1`  instruction word present on `in_instr`
- `in_instr  in  30`  instruction, [29:25] opcode, same layout the CPU fetches
- `in_last  in  1`  qualifies `in_instr` as final instruction of the program
- `in_ready  out  1`  loader can accept an instruction this cycle
- `mem_addr  out  14`  memory write address
- `mem_data  out  10`  memory write data
- `mem_we  out  1`  memory write strobe, one word per cycle
- `cpu_rst  out  1`  active-high hold for the CPU (drives its `rst`)
- `busy  out  1`  session in progress
- `done  out  1`  program fully stored, CPU released
- `error  out  1`  address space exhausted, load aborted
- `count  out  12`  instructions stored in current session

## Operation
- FSM states: IDLE, ACCEPT, W0, W1, W2, DONE, ERR; all outputs registered or decoded from state.
- IDLE: `cpu_rst`=1, `in_ready`=0. `start` -> ACCEPT, write pointer `ptr`=BASE_ADDR, `count`=0.
- ACCEPT: `in_ready`=1, `busy`=1. On `in_valid && in_ready`: latch `in_instr`, `in_last` -> W0. Without `in_valid`, stay.
- Capture check: if `ptr` > 14'h3FFD (instruction would not fit below the top of memory) the instruction is not written -> ERR. No address wrap is ever performed.
- W0: `mem_we`=1, `mem_addr`=ptr, `mem_data`=instr[29:20].
- W1: `mem_we`=1, `mem_addr`=ptr+1, `mem_data`=instr[19:10].
- W2: `mem_we`=1, `mem_addr`=ptr+2, `mem_data`=instr[9:0]; at end of cycle `ptr`+=3, `count`+=1; latched last=1 -> DONE, else ACCEPT.
- Word order matches CPU fetch order (instrWrite 0,1,2 -> high, mid, low).
- DONE: `cpu_rst`=0, `done`=1, `busy`=0. `start` -> ACCEPT with `ptr`=BASE_ADDR, `count`=0, `cpu_rst` reasserted the same edge, `done` cleared.
- ERR: `cpu_rst`=1, `error`=1, `busy`=0; `count` holds instructions stored. `start` -> ACCEPT as above, `error` cleared.
- `start` in ACCEPT/W0/W1/W2 is ignored.
- `count` saturates at 12'hFFF (never reached with default parameters: max 2730).
- `mem_addr`/`mem_data` are 0 whenever `mem_we`=0.

## Timing
- Reset values: state IDLE, `cpu_rst`=1, `in_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_data`=0, `busy`=0, `done`=0, `error`=0, `count`=0, `ptr`=BASE_ADDR.
- `rst_n` low mid-session: immediate return to reset values; a partially written instruction stays partially written in memory; no further writes.
- `start` at edge N -> `in_ready`=1 in cycle N+1.
- Handshake at edge H -> `mem_we` high cycles H+1..H+3 -> `in_ready` high again cycle H+4. Throughput: one instruction per 4 cycles.
- Final W2 edge -> `cpu_rst`=0 and `done`=1 from the next cycle; memory write of the last word completes on that same edge, so the CPU's first fetch sees the full program.
- Overflow: handshake with bad `ptr` -> `error`=1, `in_ready`=0 next cycle, `mem_we` never asserted for it.

## Test plan
- Single instruction 30'h2AB_CDEF with `in_last`=1 after `start` -> writes 0x2000=instr[29:20], 0x2001=instr[19:10], 0x2002=instr[9:0] on three consecutive cycles, then `done`=1, `cpu_rst`=0, `count`=1.
- Three instructions with 2-cycle `in_valid` gaps -> addresses 0x2000..0x2008 written in order, no write during gaps, `count`=3, `in_ready` low in every W cycle.
- BASE_ADDR=14'h3FFA, four instructions -> first at 0x3FFA..0x3FFC, second at 0x3FFD..0x3FFF, third -> `error`=1, `count`=2, no write, `cpu_rst` stays 1.
- `rst_n` pulsed low during W1 -> outputs return to reset values asynchronously, no write to ptr+2, FSM in IDLE.
- `start` while in ACCEPT and W0 -> ignored, `count`/`ptr` unchanged.
- From DONE, `start` then one instruction -> `cpu_rst` high the cycle after `start`, write resumes at 0x2000, `count`=1, `done` re-asserted at end.
